// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline stages.
`default_nettype none

package cpu_pkg;

  localparam int XLEN = 16;
  localparam logic [XLEN-1:0] INSTR_STEP = 16'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per handshake and
// offers PC+2 / PC+imm candidates to the PC-source select stage.
`default_nettype none

module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  input  logic            instr_ack,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus2,
  output logic [XLEN-1:0] pc_plus_imm,
  input  logic            flush,
  output logic            fetch_err
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:1], 1'b0};

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic         pc_load;
  logic         instr_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // flush outranks both ack and an in-flight memory beat
  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    instr_load  = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (flush) begin
          pc_load = 1'b1;
        end else if (imem_ready) begin
          instr_load = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (flush || instr_ack) begin
          pc_load   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC_ALIGNED;
      instr     <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (pc_load) begin
        pc <= {next_pc[XLEN-1:1], 1'b0};
        if (next_pc[0]) begin
          fetch_err <= 1'b1;
        end
      end
      if (instr_load) begin
        instr <= imem_rdata;
      end
    end
  end

  assign imem_addr   = pc;
  assign pc_plus2    = pc + INSTR_STEP;
  assign pc_plus_imm = pc + imm;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory beats push expected words,
// instr_valid pops and compares them.
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ack;
  logic [15:0] next_pc;
  logic [15:0] imm;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [15:0] pc_plus_imm;
  logic        flush;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;

  instr_fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ack   (instr_ack),
    .next_pc     (next_pc),
    .imm         (imm),
    .pc          (pc),
    .pc_plus2    (pc_plus2),
    .pc_plus_imm (pc_plus_imm),
    .flush       (flush),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One memory beat while in REQ; the word is expected on instr next cycle.
  task automatic beat(input logic [15:0] data);
    imem_ready = 1'b1;
    imem_rdata = data;
    exp_q.push_back(data);
    tick();
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic ack_to(input logic [15:0] target);
    next_pc   = target;
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0000; instr_ack = 1'b0;
    next_pc = 16'h0000; imm = 16'h0000; flush = 1'b0;
    tick(); tick();
    checks++;
    if (pc !== 16'h0100 || instr !== 16'h0000 || instr_valid !== 1'b0 ||
        imem_req !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: pc=%h instr=%h valid=%b req=%b err=%b, want 0100 0000 0 0 0",
               pc, instr, instr_valid, imem_req, fetch_err);
    end
    rst_n = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 16'h1111;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, want 1 0100 0", imem_req, imem_addr, instr_valid);
    end
    beat(16'h1111);
    checks++;
    if (instr_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL first_valid: valid=%b queued=%0d, want 1 and a queued word", instr_valid, exp_q.size());
    end else begin
      exp_word = exp_q.pop_front();
      checks++;
      if (instr !== exp_word || pc_plus2 !== 16'h0102) begin
        errors++;
        $display("FAIL first_instr: instr=%h pc_plus2=%h, want %h 0102", instr, pc_plus2, exp_word);
      end
    end
    ack_to(16'h0100);
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_addr !== 16'h0100 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_state_%0d: addr=%h req=%b valid=%b, want 0100 1 0", i, imem_addr, imem_req, instr_valid);
      end
    end
    beat(16'hA5C3);
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word) begin
      errors++;
      $display("FAIL wait_state_data: valid=%b instr=%h, want 1 %h", instr_valid, instr, exp_word);
    end
  endtask

  task automatic test_wrap();
    ack_to(16'hFFFE);
    checks++;
    if (pc !== 16'hFFFE || imem_req !== 1'b1 || pc_plus2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h req=%b pc_plus2=%h, want FFFE 1 0000", pc, imem_req, pc_plus2);
    end
    beat(16'h1234);
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word) begin
      errors++;
      $display("FAIL wrap_data: valid=%b instr=%h, want 1 %h", instr_valid, instr, exp_word);
    end
    ack_to(16'h0000);
    checks++;
    if (pc !== 16'h0000 || pc_plus2 !== 16'h0002) begin
      errors++;
      $display("FAIL wrap_advance: pc=%h pc_plus2=%h, want 0000 0002", pc, pc_plus2);
    end
  endtask

  task automatic test_branch();
    beat(16'h2222);
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word) begin
      errors++;
      $display("FAIL branch_fetch0: valid=%b instr=%h, want 1 %h", instr_valid, instr, exp_word);
    end
    ack_to(16'h0010);
    imm = 16'hFFF0;
    #1;
    checks++;
    if (pc_plus_imm !== 16'h0000) begin
      errors++;
      $display("FAIL branch_back: pc_plus_imm=%h, want 0000", pc_plus_imm);
    end
    imm = 16'h0020;
    #1;
    checks++;
    if (pc_plus_imm !== 16'h0030) begin
      errors++;
      $display("FAIL branch_fwd: pc_plus_imm=%h, want 0030", pc_plus_imm);
    end
    imm = 16'hFFF0;
    beat(16'h3333);
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word) begin
      errors++;
      $display("FAIL branch_fetch1: valid=%b instr=%h, want 1 %h", instr_valid, instr, exp_word);
    end
    ack_to(16'h0000);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL branch_target: req=%b addr=%h, want 1 0000", imem_req, imem_addr);
    end
    imm = 16'h0000;
  endtask

  task automatic test_flush();
    // flush with a simultaneous memory beat: the beat must be dropped
    flush = 1'b1; imem_ready = 1'b1; imem_rdata = 16'hDEAD; next_pc = 16'h0040;
    tick();
    flush = 1'b0; imem_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 16'h0040 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_req: valid=%b addr=%h req=%b, want 0 0040 1", instr_valid, imem_addr, imem_req);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: valid=%b, want 0", instr_valid);
    end
    beat(16'hBEEF);
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word) begin
      errors++;
      $display("FAIL flush_refetch: valid=%b instr=%h, want 1 %h", instr_valid, instr, exp_word);
    end
    flush = 1'b1; next_pc = 16'h0050;
    tick();
    flush = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 16'h0050 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_hold: valid=%b addr=%h req=%b, want 0 0050 1", instr_valid, imem_addr, imem_req);
    end
    // ack outside HOLD is ignored
    instr_ack = 1'b1; next_pc = 16'h0080;
    tick();
    instr_ack = 1'b0;
    checks++;
    if (pc !== 16'h0050 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_ignored: pc=%h req=%b valid=%b, want 0050 1 0", pc, imem_req, instr_valid);
    end
  endtask

  task automatic test_misaligned();
    beat(16'h4444);
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pre: valid=%b instr=%h err=%b, want 1 %h 0", instr_valid, instr, fetch_err, exp_word);
    end
    ack_to(16'h0023);
    checks++;
    if (pc !== 16'h0022 || fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_load: pc=%h err=%b, want 0022 1", pc, fetch_err);
    end
    beat(16'h5555);
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (instr !== exp_word) begin
      errors++;
      $display("FAIL misalign_fetch: instr=%h, want %h", instr, exp_word);
    end
    ack_to(16'h0030);
    checks++;
    if (pc !== 16'h0030 || fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_sticky: pc=%h err=%b, want 0030 1", pc, fetch_err);
    end
  endtask

  task automatic test_async_reset();
    // mid-cycle, well away from any rising edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 16'h0100 || instr !== 16'h0000 || instr_valid !== 1'b0 ||
        imem_req !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h instr=%h valid=%b req=%b err=%b, want 0100 0000 0 0 0",
               pc, instr, instr_valid, imem_req, fetch_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: queued=%0d, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_wrap();
    test_branch();
    test_flush();
    test_misaligned();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
